// File: rtl/jk_excite_drv.sv
// rtl/jk_excite_drv.sv - JK flip-flop bank excitation driver with verify-and-retry
module jk_excite_drv #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int DC_POLICY = 0,
    localparam int RCW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    input  logic             clr_err,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done_pulse,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [RCW-1:0]   retry_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_ERR} state_t;

    localparam logic [RCW-1:0] RMAX = RCW'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_q;
    logic             match;
    logic             retry_ok;

    // Returns {J, K}; neither policy can produce J=K=1 on any bit.
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] t,
                                                  input logic [WIDTH-1:0] q);
        if (DC_POLICY != 0)
            return {t, ~t};
        else
            return {t & ~q, ~t & q};
    endfunction

    assign match    = (q_fb == tgt_q);
    assign retry_ok = (retry_cnt < RMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tgt_valid) state_nxt = S_DRIVE;
            S_DRIVE: state_nxt = S_CHECK;
            S_CHECK: begin
                if (match)
                    state_nxt = S_IDLE;
                else if (retry_ok)
                    state_nxt = S_DRIVE;
                else
                    state_nxt = S_ERR;
            end
            S_ERR:   if (clr_err) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tgt_ready = 1'b0;
        busy      = 1'b1;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                tgt_ready = 1'b1;
                busy      = 1'b0;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    // J/K default to zero so every drive lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q      <= '0;
            J          <= '0;
            K          <= '0;
            done_pulse <= 1'b0;
            err_mask   <= '0;
            retry_cnt  <= '0;
        end else begin
            J          <= '0;
            K          <= '0;
            done_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tgt_valid) begin
                        tgt_q     <= tgt_data;
                        {J, K}    <= excite(tgt_data, q_fb);
                        retry_cnt <= '0;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        done_pulse <= 1'b1;
                    end else if (retry_ok) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        {J, K}    <= excite(tgt_q, q_fb);
                    end else begin
                        err_mask <= q_fb ^ tgt_q;
                    end
                end
                S_ERR: begin
                    if (clr_err) begin
                        err_mask  <= '0;
                        retry_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excite_drv.sv
// tb/tb_jk_excite_drv.sv - directed bench for jk_excite_drv with modelled JK banks
module tb_jk_excite_drv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       tv0 = 1'b0, ce0 = 1'b0;
    logic [7:0] td0 = 8'h00;
    logic       tr0, busy0, dp0, err0;
    logic [7:0] j0, k0, em0;
    logic [1:0] rc0;
    logic [7:0] q0 = 8'h00;

    logic       tv1 = 1'b0, ce1 = 1'b0;
    logic [7:0] td1 = 8'h00;
    logic       tr1, busy1, dp1, err1;
    logic [7:0] j1, k1, em1;
    logic [1:0] rc1;
    logic [7:0] q1 = 8'h00;

    logic       pl0 = 1'b0, pl1 = 1'b0;
    logic [7:0] pv0 = 8'h00, pv1 = 8'h00;
    logic [7:0] stuck0 = 8'h00;
    logic [7:0] flip0 = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_excite_drv #(.WIDTH(8), .MAX_RETRY(3), .DC_POLICY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tv0), .tgt_data(td0), .tgt_ready(tr0),
        .q_fb(q0), .clr_err(ce0), .J(j0), .K(k0), .busy(busy0), .done_pulse(dp0),
        .err(err0), .err_mask(em0), .retry_cnt(rc0)
    );

    jk_excite_drv #(.WIDTH(8), .MAX_RETRY(3), .DC_POLICY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tv1), .tgt_data(td1), .tgt_ready(tr1),
        .q_fb(q1), .clr_err(ce1), .J(j1), .K(k1), .busy(busy1), .done_pulse(dp1),
        .err(err1), .err_mask(em1), .retry_cnt(rc1)
    );

    // Posedge JK banks: Q+ = J&~Q | ~K&Q, with stuck-at-0 and one-shot flip faults on bank 0.
    always @(posedge clk) begin
        if (pl0) q0 <= pv0;
        else     q0 <= (((j0 & ~q0) | (~k0 & q0)) ^ flip0) & ~stuck0;
        if (pl1) q1 <= pv1;
        else     q1 <= (j1 & ~q1) | (~k1 & q1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [7:0] v0, input logic [7:0] v1);
        pl0 = 1'b1; pv0 = v0;
        pl1 = 1'b1; pv1 = v1;
        step();
        pl0 = 1'b0; pl1 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        n_cmp++; if ({j0, k0} !== 16'h0000) begin n_err++; $display("FAIL reset_jk: got %h want 0000", {j0, k0}); end
        n_cmp++; if (tr0 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", tr0); end
        n_cmp++; if ({err0, dp0, busy0} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {err0, dp0, busy0}); end
        n_cmp++; if ({em0, rc0} !== 10'h000) begin n_err++; $display("FAIL reset_mask_cnt: got %h want 000", {em0, rc0}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_drive;
        preload(8'h00, 8'h00);
        tv0 = 1'b1; td0 = 8'h5A;
        step();
        tv0 = 1'b0;
        n_cmp++; if (j0 !== 8'h5A) begin n_err++; $display("FAIL rst_mid_pre_j: got %h want 5a", j0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({j0, k0} !== 16'h0000) begin n_err++; $display("FAIL rst_mid_jk: got %h want 0000", {j0, k0}); end
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({dp0, err0, tr0} !== 3'b001) begin n_err++; $display("FAIL rst_mid_after[%0d]: dp/err/rdy got %b want 001", i, {dp0, err0, tr0}); end
            step();
        end
    endtask

    task automatic test_minimal;
        preload(8'h00, 8'h00);
        tv0 = 1'b1; td0 = 8'hA5;
        step();
        tv0 = 1'b0;
        n_cmp++; if ({j0, k0} !== 16'hA500) begin n_err++; $display("FAIL min_a5_jk: got %h want a500", {j0, k0}); end
        step();
        n_cmp++; if ({dp0, busy0} !== 2'b01) begin n_err++; $display("FAIL min_a5_c2: dp/busy got %b want 01", {dp0, busy0}); end
        step();
        n_cmp++; if ({dp0, q0} !== 9'h1A5) begin n_err++; $display("FAIL min_a5_done: dp/q got %h want 1a5", {dp0, q0}); end
        tv0 = 1'b1; td0 = 8'h0F;
        step();
        tv0 = 1'b0;
        n_cmp++; if ({j0, k0} !== 16'h0AA0) begin n_err++; $display("FAIL min_0f_jk: got %h want 0aa0", {j0, k0}); end
        step(2);
        n_cmp++; if ({dp0, q0} !== 9'h10F) begin n_err++; $display("FAIL min_0f_done: dp/q got %h want 10f", {dp0, q0}); end
    endtask

    task automatic test_forced;
        preload(8'h0F, 8'hFF);
        tv1 = 1'b1; td1 = 8'h3C;
        step();
        tv1 = 1'b0;
        n_cmp++; if ({j1, k1} !== 16'h3CC3) begin n_err++; $display("FAIL forced_jk: got %h want 3cc3", {j1, k1}); end
        step(2);
        n_cmp++; if ({dp1, q1} !== 9'h13C) begin n_err++; $display("FAIL forced_done: dp/q got %h want 13c", {dp1, q1}); end
        n_cmp++; if (rc1 !== 2'd0) begin n_err++; $display("FAIL forced_retry: got %0d want 0", rc1); end
    endtask

    task automatic test_stuck_err;
        preload(8'h00, 8'h3C);
        stuck0 = 8'h04;
        tv0 = 1'b1; td0 = 8'h04;
        step();
        tv0 = 1'b0;
        for (int d = 0; d < 4; d++) begin
            n_cmp++; if ({j0, k0, rc0} !== {16'h0400, 2'(d)}) begin n_err++; $display("FAIL stuck_drive[%0d]: j/k/rc got %h/%h/%0d want 04/00/%0d", d, j0, k0, rc0, d); end
            step(2);
        end
        // Now at c0+9.
        n_cmp++; if ({err0, tr0, busy0, em0} !== {3'b101, 8'h04}) begin n_err++; $display("FAIL stuck_err: err/rdy/busy/mask got %b%b%b/%h want 101/04", err0, tr0, busy0, em0); end
        n_cmp++; if (rc0 !== 2'd3) begin n_err++; $display("FAIL stuck_retry: got %0d want 3", rc0); end
        tv0 = 1'b1; td0 = 8'h00;
        step(2);
        tv0 = 1'b0;
        n_cmp++; if ({err0, j0, k0} !== 17'h10000) begin n_err++; $display("FAIL stuck_hold: err/jk got %h want 10000", {err0, j0, k0}); end
        ce0 = 1'b1;
        step();
        ce0 = 1'b0;
        n_cmp++; if ({err0, tr0, em0, rc0} !== 12'h400) begin n_err++; $display("FAIL stuck_clear: err/rdy/mask/rc got %h want 400", {err0, tr0, em0, rc0}); end
        stuck0 = 8'h00;
        ce0 = 1'b1;
        step();
        ce0 = 1'b0;
        n_cmp++; if ({err0, tr0, busy0} !== 3'b010) begin n_err++; $display("FAIL clr_idle_ignored: err/rdy/busy got %b want 010", {err0, tr0, busy0}); end
    endtask

    task automatic test_one_retry;
        preload(8'h00, 8'h3C);
        tv0 = 1'b1; td0 = 8'h80;
        step();
        tv0 = 1'b0;
        flip0 = 8'h80;
        step();
        flip0 = 8'h00;
        n_cmp++; if (q0 !== 8'h00) begin n_err++; $display("FAIL retry_fault_q: got %h want 00", q0); end
        step();
        n_cmp++; if ({dp0, j0, rc0} !== {1'b0, 8'h80, 2'd1}) begin n_err++; $display("FAIL retry_redrive: dp/j/rc got %b/%h/%0d want 0/80/1", dp0, j0, rc0); end
        step(2);
        n_cmp++; if ({dp0, err0, rc0, q0} !== {2'b10, 2'd1, 8'h80}) begin n_err++; $display("FAIL retry_done: dp/err/rc/q got %b%b/%0d/%h want 10/1/80", dp0, err0, rc0, q0); end
    endtask

    task automatic test_back_to_back;
        preload(8'h00, 8'h3C);
        tv0 = 1'b1; td0 = 8'h11;
        step();
        td0 = 8'h22;
        step();
        n_cmp++; if (tr0 !== 1'b0) begin n_err++; $display("FAIL b2b_busy_ready: got %b want 0", tr0); end
        step();
        n_cmp++; if ({dp0, tr0, q0} !== {2'b11, 8'h11}) begin n_err++; $display("FAIL b2b_done_ready: dp/rdy/q got %b%b/%h want 11/11", dp0, tr0, q0); end
        step();
        tv0 = 1'b0;
        n_cmp++; if ({j0, k0} !== 16'h2211) begin n_err++; $display("FAIL b2b_jk: got %h want 2211", {j0, k0}); end
        step(2);
        n_cmp++; if ({dp0, q0} !== 9'h122) begin n_err++; $display("FAIL b2b_done2: dp/q got %h want 122", {dp0, q0}); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_drive();
        test_minimal();
        test_forced();
        test_stuck_err();
        test_one_retry();
        test_back_to_back();
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
